// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encodings, frame format and default sizing.
// The transmitter also uses the frame constants, so both ends agree on line polarity.
package uart_pkg;

  // Default frame sizing
  localparam int unsigned DefaultDataBits  = 8;
  localparam int unsigned DefaultOversample = 16;

  // Frame format: the start bit pulls the line low and the stop bit returns it high.
  // The idle line level equals the stop level.
  localparam logic FrameStartBit = 1'b0;
  localparam logic FrameStopBit  = 1'b1;
  localparam logic LineIdle      = 1'b1;

  // Receiver FSM encodings
  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StStart = 3'd1;
  localparam logic [2:0] StData  = 3'd2;
  localparam logic [2:0] StStop  = 3'd3;
  localparam logic [2:0] StBreak = 3'd4;

  // Counter width able to hold 0..n-1, never narrower than one bit
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchroniser for an asynchronous single-bit input.
// Flops reset to the idle line level so a reset never fakes a start edge.
module uart_sync
  import uart_pkg::*;
#(
  parameter int unsigned Stages = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [Stages-1:0] sync_q;

  if (Stages == 1) begin : g_one
    // Single flop: capture the input directly
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        sync_q <= LineIdle;
      end else begin
        sync_q <= d_i;
      end
    end
  end else begin : g_chain
    // Shift the input through the chain, oldest sample at the top
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        sync_q <= {Stages{LineIdle}};
      end else begin
        sync_q <= {sync_q[Stages-2:0], d_i};
      end
    end
  end

  assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/uart_receiver.sv
// 8N1-style UART receiver: oversampled start detection, mid-bit data sampling,
// one-cycle done / framing-error pulses, and break handling so a held-low
// line cannot retrigger frames.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS   = DefaultDataBits,
  // Must be even and at least 4
  parameter int unsigned OVERSAMPLE  = DefaultOversample,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 rx_enb,
  output logic [DATA_BITS-1:0] rx_data_out,
  output logic                 rx_done,
  output logic                 rx_busy,
  output logic                 rx_frame_err
);

  localparam int unsigned TickW = cnt_width(OVERSAMPLE);
  localparam int unsigned BitW  = cnt_width(DATA_BITS);

  // Start bit is re-checked half a bit after detection; data and stop bits a full bit apart
  localparam logic [TickW-1:0] TickMid  = TickW'(OVERSAMPLE / 2 - 1);
  localparam logic [TickW-1:0] TickLast = TickW'(OVERSAMPLE - 1);
  localparam logic [BitW-1:0]  BitLast  = BitW'(DATA_BITS - 1);

  logic                 rx_s;
  logic [2:0]           state_q, state_d;
  logic [TickW-1:0]     tick_q, tick_d;
  logic [BitW-1:0]      bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 busy_q;

  uart_sync #(
    .Stages (SYNC_STAGES)
  ) u_rx_sync (
    .clk_i (clk),
    .rst_i (rst),
    .d_i   (rx),
    .q_o   (rx_s)
  );

  // Next-state logic: everything holds unless this cycle carries an oversample tick
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    if (rx_enb) begin
      case (state_q)
        StIdle: begin
          if (rx_s == FrameStartBit) begin
            state_d = StStart;
            tick_d  = '0;
          end
        end

        StStart: begin
          if (tick_q == TickMid) begin
            if (rx_s == FrameStartBit) begin
              state_d = StData;
              tick_d  = '0;
              bit_d   = '0;
            end else begin
              // Low pulse shorter than half a bit: treat as noise
              state_d = StIdle;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end

        StData: begin
          if (tick_q == TickLast) begin
            // LSB arrives first, so shift in from the top
            shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
            tick_d  = '0;
            if (bit_q == BitLast) begin
              state_d = StStop;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end

        StStop: begin
          if (tick_q == TickLast) begin
            tick_d = '0;
            if (rx_s == FrameStopBit) begin
              // Leaving at mid stop bit leaves half a bit to catch a back-to-back start
              data_d  = shift_q;
              done_d  = 1'b1;
              state_d = StIdle;
            end else begin
              err_d   = 1'b1;
              state_d = StBreak;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end

        StBreak: begin
          // Hold off until the line is released, otherwise a break would look like frames
          if (rx_s == LineIdle) begin
            state_d = StIdle;
          end
        end

        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // State and output registers; reset aborts any frame in progress
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= (state_d != StIdle);
    end
  end

  assign rx_data_out  = data_q;
  assign rx_done      = done_q;
  assign rx_busy      = busy_q;
  assign rx_frame_err = err_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver with a tick-driven behavioural reference
// checked against the DUT on every falling clock edge.
module tb_uart_receiver;
  import uart_pkg::*;

  localparam int unsigned DataBits = 8;
  localparam int unsigned Os       = 16;
  localparam int unsigned Sync     = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx = 1'b1;
  logic       rx_enb = 1'b0;
  logic [7:0] rx_data_out;
  logic       rx_done;
  logic       rx_busy;
  logic       rx_frame_err;

  uart_receiver #(
    .DATA_BITS   (DataBits),
    .OVERSAMPLE  (Os),
    .SYNC_STAGES (Sync)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx           (rx),
    .rx_enb       (rx_enb),
    .rx_data_out  (rx_data_out),
    .rx_done      (rx_done),
    .rx_busy      (rx_busy),
    .rx_frame_err (rx_frame_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Oversample tick generator: one tick every enb_div clocks
  int enb_div = 2;
  int div_cnt = 0;
  int tick_total = 0;
  initial begin
    forever begin
      @(posedge clk);
      if (rx_enb) tick_total++;
      #2;
      rx_enb = (div_cnt == 0);
      div_cnt = (div_cnt + 1 >= enb_div) ? 0 : div_cnt + 1;
    end
  end

  // ---------------- reference model ----------------
  logic [7:0] exp_data = 8'h00;
  logic       exp_done = 1'b0;
  logic       exp_err  = 1'b0;
  logic       exp_busy = 1'b0;
  logic       hist [Sync];
  logic       m_rxs;
  logic       m_en;
  logic       m_abort;

  initial for (int i = 0; i < Sync; i++) hist[i] = 1'b1;

  // One clock edge: the line value seen by the receiver lags the pin by Sync clocks
  task automatic m_edge();
    @(posedge clk or posedge rst);
    if (rst) begin
      exp_data = 8'h00;
      exp_done = 1'b0;
      exp_err  = 1'b0;
      exp_busy = 1'b0;
      for (int i = 0; i < Sync; i++) hist[i] = 1'b1;
      m_abort = 1'b1;
      m_en = 1'b0;
      wait (rst == 1'b0);
    end else begin
      exp_done = 1'b0;
      exp_err  = 1'b0;
      m_en  = rx_enb;
      m_rxs = hist[Sync-1];
      for (int i = Sync - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = rx;
    end
  endtask

  task automatic m_tick(output logic rs);
    do m_edge(); while (!m_abort && !m_en);
    rs = m_rxs;
  endtask

  // Frame reception as a timed sequence of tick counts
  initial begin : model
    logic       rs;
    logic [7:0] byte_v;
    byte_v = 8'h00;
    forever begin
      m_abort = 1'b0;
      rs = 1'b1;
      while (!m_abort && rs) m_tick(rs);
      if (!m_abort) begin
        exp_busy = 1'b1;
        for (int i = 0; i < Os / 2 && !m_abort; i++) m_tick(rs);
        if (!m_abort && rs) begin
          exp_busy = 1'b0;
        end else if (!m_abort) begin
          for (int b = 0; b < DataBits && !m_abort; b++) begin
            for (int i = 0; i < Os && !m_abort; i++) m_tick(rs);
            byte_v[b] = rs;
          end
          for (int i = 0; i < Os && !m_abort; i++) m_tick(rs);
          if (!m_abort) begin
            if (rs) begin
              exp_data = byte_v;
              exp_done = 1'b1;
              exp_busy = 1'b0;
            end else begin
              exp_err = 1'b1;
              rs = 1'b0;
              while (!m_abort && !rs) m_tick(rs);
              if (!m_abort) exp_busy = 1'b0;
            end
          end
        end
      end
    end
  end

  // Cycle-by-cycle compare and received-byte monitor
  logic [7:0] got_q [$];
  int n_err = 0;
  int done_tick = 0;
  initial begin
    forever begin
      @(negedge clk);
      check("data", 32'(rx_data_out), 32'(exp_data));
      check("done", 32'(rx_done), 32'(exp_done));
      check("frame_err", 32'(rx_frame_err), 32'(exp_err));
      check("busy", 32'(rx_busy), 32'(exp_busy));
      if (rx_done) begin
        got_q.push_back(rx_data_out);
        done_tick = tick_total;
      end
      if (rx_frame_err) n_err++;
    end
  end

  // ---------------- stimulus ----------------
  int start_tick = 0;

  // Hold the line at b for exactly `ticks` oversample ticks
  task automatic send_bit(input logic b, input int ticks);
    int c;
    c = 0;
    rx = b;
    while (c < ticks) begin
      @(posedge clk);
      if (rx_enb) c++;
    end
    #2;
  endtask

  // Start bit, data LSB first, then the stop level; the line is left at stop_v
  task automatic send_frame(input logic [7:0] d, input int stop_ticks, input logic stop_v);
    start_tick = tick_total;
    send_bit(FrameStartBit, Os);
    for (int i = 0; i < 8; i++) send_bit(d[i], Os);
    send_bit(stop_v, stop_ticks);
  endtask

  logic [7:0] exp_q [$];
  int lat;
  int n_got;

  initial begin
    #1 rst = 1'b1;
    repeat (4) @(posedge clk);
    #2 rst = 1'b0;
    send_bit(1'b1, 8);

    // Single frame, latency from the start edge
    send_frame(8'hA5, Os, 1'b1);
    exp_q.push_back(8'hA5);
    send_bit(1'b1, 4);
    lat = done_tick - start_tick;
    check("latency_in_range", 32'((lat >= 152) && (lat <= 155)), 32'd1);
    check("a5_data", 32'(rx_data_out), 32'hA5);
    check("model_a5", 32'(exp_data), 32'hA5);
    check("a5_no_err", 32'(n_err), 32'd0);

    // Reset in the middle of the data bits
    send_bit(FrameStartBit, Os);
    send_bit(1'b1, Os);
    send_bit(1'b0, Os);
    send_bit(1'b1, 5);
    rst = 1'b1;
    @(negedge clk);
    check("rst_data", 32'(rx_data_out), 32'h00);
    check("rst_busy", 32'(rx_busy), 32'd0);
    check("rst_done", 32'(rx_done), 32'd0);
    check("rst_err", 32'(rx_frame_err), 32'd0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    send_bit(1'b1, 2 * Os);
    send_frame(8'h5A, Os, 1'b1);
    exp_q.push_back(8'h5A);
    send_bit(1'b1, 4);
    check("5a_data", 32'(rx_data_out), 32'h5A);

    // Glitch shorter than half a bit
    n_got = got_q.size();
    send_bit(1'b0, 3);
    send_bit(1'b1, 20);
    check("glitch_busy", 32'(rx_busy), 32'd0);
    check("glitch_no_done", 32'(got_q.size()), 32'(n_got));
    check("glitch_no_err", 32'(n_err), 32'd0);

    // Framing error followed by a held-low line
    send_frame(8'hA5, Os, 1'b1);
    exp_q.push_back(8'hA5);
    send_frame(8'h3C, 2 * Os, 1'b0);
    check("ferr_count", 32'(n_err), 32'd1);
    check("ferr_keeps_data", 32'(rx_data_out), 32'hA5);
    check("break_busy", 32'(rx_busy), 32'd1);
    send_bit(1'b1, 2 * Os);
    check("break_released", 32'(rx_busy), 32'd0);
    send_frame(8'h81, Os, 1'b1);
    exp_q.push_back(8'h81);
    send_bit(1'b1, 4);
    check("81_data", 32'(rx_data_out), 32'h81);

    // Back-to-back frames with a single stop bit
    send_frame(8'h00, Os, 1'b1);
    send_frame(8'hFF, Os, 1'b1);
    send_frame(8'h55, Os, 1'b1);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h55);
    send_bit(1'b1, 2 * Os);
    check("b2b_last", 32'(rx_data_out), 32'h55);
    check("directed_count", 32'(got_q.size()), 32'd7);

    // Loopback-style random stream, one tick per clock
    enb_div = 1;
    send_bit(1'b1, 2 * Os);
    for (int i = 0; i < 256; i++) begin
      logic [7:0] d;
      d = 8'($urandom_range(0, 255));
      exp_q.push_back(d);
      send_frame(d, Os, 1'b1);
    end
    send_bit(1'b1, 2 * Os);

    check("total_count", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check($sformatf("byte_%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
    end
    check("total_frame_errs", 32'(n_err), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Serial-to-parallel UART receive stage; consumes the line produced by the UART transmitter (8N1, LSB first, idle high).
- Samples the asynchronous rx line using a 16x oversample strobe from the shared baud generator.
- Delivers each good byte with a one-cycle done pulse, and flags framing errors.

Parameters:
- DATA_BITS, 8, payload bits per frame.
- OVERSAMPLE, 16, rx_enb ticks per bit period. Must be even and at least 4.
- SYNC_STAGES, 2, flops in the rx input synchroniser.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- rx  input  1  asynchronous serial line; idle high.
- rx_enb  input  1  oversample tick; a single-clk pulse occurring OVERSAMPLE times per bit.
- rx_data_out  output  DATA_BITS  last correctly received byte.
- rx_done  output  1  one-clk pulse when rx_data_out is updated.
- rx_busy  output  1  high whenever the FSM is not in IDLE.
- rx_frame_err  output  1  one-clk pulse when the stop bit samples low.

Behaviour:
- Reset (async, active-high):
  - Synchroniser flops reset to 1.
  - rx_data_out=0, rx_done=0, rx_busy=0, rx_frame_err=0.
  - Shift register, tick_cnt and bit_index reset to 0; state=IDLE.
  - Reset mid-frame aborts the frame silently.
- Input path:
  - rx passes through SYNC_STAGES flops; all decisions use the synchronised value, rx_s.
  - Added latency is SYNC_STAGES clks.
- FSM advances only on clk edges where rx_enb=1. Between ticks, all state is held. All outputs are registered.
- IDLE:
  - On a tick with rx_s=0: go to START, tick_cnt=0.
- START:
  - Each tick, tick_cnt++.
  - At tick_cnt==OVERSAMPLE/2-1 (mid start bit), re-sample rx_s.
    - rx_s=0: go to DATA, tick_cnt=0, bit_index=0.
    - rx_s=1: glitch; return to IDLE with no output pulse.
- DATA:
  - Each tick, tick_cnt++.
  - At tick_cnt==OVERSAMPLE-1 (mid data bit): shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]}, tick_cnt=0.
  - After bit_index==DATA_BITS-1 is sampled: go to STOP. Otherwise bit_index++.
- STOP:
  - At tick_cnt==OVERSAMPLE-1 (mid stop bit), sample rx_s.
    - rx_s=1: rx_data_out<=shift_reg, rx_done=1 for one clk, go to IDLE.
    - rx_s=0: rx_frame_err=1 for one clk, rx_data_out unchanged, go to BREAK.
- BREAK:
  - Wait for a tick with rx_s=1, then go to IDLE.
  - Prevents a held-low line (break condition) from retriggering frames.
- rx_done and rx_frame_err are never high in the same cycle.
- rx_busy is registered: high the clk after leaving IDLE, low the clk after returning to IDLE.
- Latency: rx_done rises 1 clk after the rx_enb tick at the stop-bit midpoint. That is about 9.5 bit times after the start edge, plus SYNC_STAGES clks.
- Back-to-back frames:
  - Returning to IDLE at the stop-bit midpoint leaves half a bit period to detect the next start edge.
  - Frames with a single stop bit are received without loss.
- rx_enb stuck low: FSM frozen indefinitely; this is legal.

Decomposition:
- Shared package uart_pkg holds:
  - State encodings IDLE/START/DATA/STOP/BREAK (3 bits).
  - Default DATA_BITS and OVERSAMPLE constants.
  - Frame format constants (start=0, stop=1), also used by the transmitter.
- Sub-module uart_sync: SYNC_STAGES-deep flop chain with reset value 1, reusable for other async inputs.

Test Plan:
1. Assert rst mid-DATA while rx toggles -> next clk: all outputs 0, rx_busy=0. After release, the next clean frame 0x5A is received correctly.
2. Drive frame 0xA5 at OVERSAMPLE=16 ticks/bit -> rx_data_out=0xA5 and a single one-clk rx_done, about 152 ticks after the start edge. No rx_frame_err.
3. Pull rx low for 3 ticks, then high -> START aborts at mid-sample. No rx_done or rx_frame_err; rx_busy returns to 0.
4. Drive data 0x3C with the stop bit held low for 2 bit times -> one rx_frame_err pulse, rx_data_out keeps the prior 0xA5. No new frame starts until rx returns high; the following 0x81 frame is received correctly.
5. Send back-to-back frames 0x00, 0xFF, 0x55 with one stop bit each -> three rx_done pulses with matching rx_data_out values, in order.
6. Loopback: transmitter tx to rx, transmitter tx_enb = every 16th rx_enb, random 256 bytes -> all bytes match and there are 0 framing errors.
